// File: rtl/semaforo.sv
// -----------------------------------------------------------------------------
// semaforo -- two-way traffic-light controller (approaches A and B)
//
// A Moore FSM with four phases. Each phase is timed by an 8-bit down-counter:
//   P0  A green  / B red
//   P1  A yellow / B red
//   P2  A red    / B green
//   P3  A red    / B yellow
// Holding the request button during A's green phase cuts that phase short.
//
// Ports:
//   clk  in   system clock, all state changes on its rising edge
//   rst  in   asynchronous active-low reset (back to P0 with a fresh green count)
//   bt   in   request button, level, sampled on the rising edge
//   A    out  light A, one-hot {red, yellow, green}
//   B    out  light B, same encoding as A
// -----------------------------------------------------------------------------
module semaforo #(
    parameter logic [7:0] T_VERDE    = 8'd1,
    parameter logic [7:0] T_AMARELO  = 8'd3,
    parameter logic [7:0] T_VERMELHO = 8'd2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bt,
    output logic [2:0] A,
    output logic [2:0] B
);

    // Counter reload values (duration - 1). A duration of 0 is treated as 1,
    // so the reload is clamped at 0 instead of wrapping to 255.
    localparam logic [7:0] L_VERDE    = (T_VERDE    == 8'd0) ? 8'd0 : T_VERDE    - 8'd1;
    localparam logic [7:0] L_AMARELO  = (T_AMARELO  == 8'd0) ? 8'd0 : T_AMARELO  - 8'd1;
    localparam logic [7:0] L_VERMELHO = (T_VERMELHO == 8'd0) ? 8'd0 : T_VERMELHO - 8'd1;

    localparam logic [2:0] LUZ_VERDE    = 3'b001;
    localparam logic [2:0] LUZ_AMARELO  = 3'b010;
    localparam logic [2:0] LUZ_VERMELHO = 3'b100;

    typedef enum logic [1:0] {
        P0 = 2'd0,  // A green,  B red
        P1 = 2'd1,  // A yellow, B red
        P2 = 2'd2,  // A red,    B green
        P3 = 2'd3   // A red,    B yellow
    } phase_t;

    phase_t     r_phase;
    phase_t     w_phase_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase <= P0;
            r_cnt   <= L_VERDE;
        end else begin
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt;
        // The button only matters in P0 and is not remembered elsewhere.
        if (r_phase == P0 && bt) begin
            w_phase_nxt = P1;
            w_cnt_nxt   = L_AMARELO;
        end else if (r_cnt == 8'd0) begin
            case (r_phase)
                P0: begin
                    w_phase_nxt = P1;
                    w_cnt_nxt   = L_AMARELO;
                end
                P1: begin
                    w_phase_nxt = P2;
                    w_cnt_nxt   = L_VERMELHO;
                end
                P2: begin
                    w_phase_nxt = P3;
                    w_cnt_nxt   = L_AMARELO;
                end
                default: begin
                    w_phase_nxt = P0;
                    w_cnt_nxt   = L_VERDE;
                end
            endcase
        end else begin
            w_cnt_nxt = r_cnt - 8'd1;
        end
    end

    // Moore decode. The default of both-red is the safe state; every phase
    // overrides it with exactly one non-red light at most.
    always_comb begin
        A = LUZ_VERMELHO;
        B = LUZ_VERMELHO;
        case (r_phase)
            P0: begin
                A = LUZ_VERDE;
                B = LUZ_VERMELHO;
            end
            P1: begin
                A = LUZ_AMARELO;
                B = LUZ_VERMELHO;
            end
            P2: begin
                A = LUZ_VERMELHO;
                B = LUZ_VERDE;
            end
            default: begin
                A = LUZ_VERMELHO;
                B = LUZ_AMARELO;
            end
        endcase
    end

endmodule

// File: tb/tb_semaforo.sv
// -----------------------------------------------------------------------------
// tb_semaforo -- bench for semaforo.
// Two instances share clock and reset: u_def uses the default timings
// (1/3/2/3), u_long uses T_VERDE=5 so the button shortening is visible.
// The reference model tracks, per instance, the current phase index and the
// number of edges already spent in it, and advances using the phase durations.
// -----------------------------------------------------------------------------
module tb_semaforo;

    logic       clk;
    logic       rst;
    logic       bt_def;
    logic       bt_long;
    logic [2:0] a_def;
    logic [2:0] b_def;
    logic [2:0] a_long;
    logic [2:0] b_long;

    int checks;
    int failures;

    // model state: index 0 = u_def, index 1 = u_long
    int m_ph [2];
    int m_el [2];
    int m_dur[2][4];
    logic [2:0] lamp_a[4];
    logic [2:0] lamp_b[4];

    semaforo u_def (
        .clk (clk),
        .rst (rst),
        .bt  (bt_def),
        .A   (a_def),
        .B   (b_def)
    );

    semaforo #(
        .T_VERDE    (8'd5),
        .T_AMARELO  (8'd3),
        .T_VERMELHO (8'd2)
    ) u_long (
        .clk (clk),
        .rst (rst),
        .bt  (bt_long),
        .A   (a_long),
        .B   (b_long)
    );

    // Irregular clock: random high/low widths, glitch-free, each at least 2.
    initial begin
        clk = 1'b0;
        #10;
        forever begin
            #($urandom_range(7, 2)) clk = 1'b1;
            #($urandom_range(7, 2)) clk = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ph[i] = 0;
            m_el[i] = 0;
        end
    endfunction

    function automatic void model_edge(input int idx, input logic btv);
        if (!rst) begin
            m_ph[idx] = 0;
            m_el[idx] = 0;
        end else if ((m_ph[idx] == 0 && btv) || (m_el[idx] + 1 >= m_dur[idx][m_ph[idx]])) begin
            m_ph[idx] = (m_ph[idx] + 1) % 4;
            m_el[idx] = 0;
        end else begin
            m_el[idx] = m_el[idx] + 1;
        end
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".Adef"},  {5'd0, a_def},  {5'd0, lamp_a[m_ph[0]]});
        chk({tag, ".Bdef"},  {5'd0, b_def},  {5'd0, lamp_b[m_ph[0]]});
        chk({tag, ".Along"}, {5'd0, a_long}, {5'd0, lamp_a[m_ph[1]]});
        chk({tag, ".Blong"}, {5'd0, b_long}, {5'd0, lamp_b[m_ph[1]]});
        chk({tag, ".safeDef"},  {7'd0, (a_def  == 3'b100) || (b_def  == 3'b100)}, 8'd1);
        chk({tag, ".safeLong"}, {7'd0, (a_long == 3'b100) || (b_long == 3'b100)}, 8'd1);
    endtask

    // One rising edge: drive buttons, let the edge happen, update the model
    // with the values seen at the edge, then sample 1 time unit later.
    task automatic step(input logic bd, input logic bl, input string tag);
        bt_def  = bd;
        bt_long = bl;
        @(posedge clk);
        model_edge(0, bd);
        model_edge(1, bl);
        #1;
        check_all(tag);
    endtask

    // A-light for the default instance, edges 1..9 after reset release.
    logic [2:0] seq_a[9];
    logic [2:0] seq_b[9];

    initial begin
        checks   = 0;
        failures = 0;
        m_dur[0] = '{1, 3, 2, 3};
        m_dur[1] = '{5, 3, 2, 3};
        lamp_a   = '{3'b001, 3'b010, 3'b100, 3'b100};
        lamp_b   = '{3'b100, 3'b100, 3'b001, 3'b010};
        seq_a    = '{3'b010, 3'b010, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001};
        seq_b    = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b001, 3'b010, 3'b010, 3'b010, 3'b100};

        // reset asserted at t=0, clock still idle
        rst     = 1'b0;
        bt_def  = 1'b0;
        bt_long = 1'b0;
        model_reset();
        #5;
        chk("rst_idle.A", {5'd0, a_def}, 8'b001);
        chk("rst_idle.B", {5'd0, b_def}, 8'b100);
        check_all("rst_idle");

        // reset held across edges, button pressed too: nothing moves
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, "rst_hold");
            chk("rst_hold.A", {5'd0, a_long}, 8'b001);
        end

        // release and run the default sequence twice (18 edges)
        rst = 1'b1;
        for (int i = 0; i < 18; i++) begin
            step(1'b0, 1'b0, "seq");
            chk("seq_tab.A", {5'd0, a_def}, {5'd0, seq_a[i % 9]});
            chk("seq_tab.B", {5'd0, b_def}, {5'd0, seq_b[i % 9]});
        end

        // button held high on the default instance: T_VERDE=1 so the
        // sequence is the same as with bt=0
        for (int i = 0; i < 18; i++) begin
            step(1'b1, 1'b0, "bt_held");
            chk("bt_held_tab.A", {5'd0, a_def}, {5'd0, seq_a[i % 9]});
        end

        // fresh reset, then button at the 2nd edge of P0 on the long instance
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        check_all("rst2");
        rst = 1'b1;
        step(1'b0, 1'b0, "press_e1");
        chk("press_e1.Along", {5'd0, a_long}, 8'b001);
        step(1'b0, 1'b1, "press_e2");
        chk("press_e2.Along", {5'd0, a_long}, 8'b010);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "after_press");
        chk("after_press.Along", {5'd0, a_long}, 8'b100);
        chk("after_press.Blong", {5'd0, b_long}, 8'b001);

        // button held during P1..P3 of the long instance only: no effect
        for (int i = 0; i < 20; i++) begin
            step(1'b0, (m_ph[1] != 0), "bt_outside_p0");
        end

        // run the default instance into P2, then drop reset between edges
        begin
            bit found = 1'b0;
            for (int i = 0; i < 12 && !found; i++) begin
                step(1'b0, 1'b0, "to_p2");
                if (m_ph[0] == 2) found = 1'b1;
            end
            chk("reach_p2", {7'd0, found}, 8'd1);
        end
        chk("in_p2.Adef", {5'd0, a_def}, 8'b100);
        rst = 1'b0;
        model_reset();
        #1;
        chk("async_rst.Adef", {5'd0, a_def}, 8'b001);
        chk("async_rst.Bdef", {5'd0, b_def}, 8'b100);
        check_all("async_rst");
        step(1'b0, 1'b0, "async_hold");
        rst = 1'b1;
        // long instance: P0 must last the full 5 edges after release
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, "post_rst");
            chk("post_rst.Along", {5'd0, a_long}, (i < 4) ? 8'b001 : 8'b010);
        end

        // random button traffic
        for (int i = 0; i < 150; i++) begin
            step(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/semaforo.md
Name: semaforo

Overview:
Two-way traffic-light controller for a crossing with approaches A and B. A Moore FSM with a per-phase down-counter sequences both lights through green, yellow and red. A pedestrian/request button can cut A's green phase short. It is a standalone top-level block driven by one clock, with light outputs going directly to lamp drivers.

Parameters:
- T_VERDE, 8'd1, cycles in phase A-green/B-red; legal 1..255.
- T_AMARELO, 8'd3, cycles in each yellow phase (A-yellow and B-yellow); legal 1..255.
- T_VERMELHO, 8'd2, cycles in phase A-red/B-green; legal 1..255.
- A parameter value of 0 behaves as 1.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-low (rst=0 resets immediately, independent of clk).
- bt  input  1  request button, level, sampled on rising clk edge.
- A  output  3  light A, one-hot encoded {red, yellow, green}: 3'b001 green, 3'b010 yellow, 3'b100 red.
- B  output  3  light B, same encoding as A.

Behaviour:
- State:
  - 2-bit phase register: P0 A-green/B-red, P1 A-yellow/B-red, P2 A-red/B-green, P3 A-red/B-yellow.
  - 8-bit down-counter cnt.
- Outputs: pure combinational decode of phase (Moore); no other output values ever occur.
  - P0: A=001, B=100
  - P1: A=010, B=100
  - P2: A=100, B=001
  - P3: A=100, B=010
- Reset: rst=0 forces phase=P0 and cnt=T_VERDE-1 asynchronously. A=001 and B=100 hold for the whole time rst is low.
- Each rising edge with rst=1:
  - If cnt==0: advance P0→P1→P2→P3→P0 and load cnt with (duration of the new phase)-1.
  - Else: cnt decrements by 1 and the phase holds.
- Phase duration in clock edges equals its parameter. Default full cycle = 1+3+2+3 = 9 edges.
- Button:
  - On an edge in P0 with bt=1, the next phase is P1 regardless of cnt, and cnt loads T_AMARELO-1.
  - bt is ignored in P1, P2 and P3; it is not latched or remembered.
  - With T_VERDE=1, bt has no visible effect.
- Safety invariant: A and B are never both non-red. At least one of A and B equals 100 at all times.
- Counter arithmetic: 8-bit unsigned; never decremented below 0. Parameter-1 computed at elaboration.
- Reset mid-phase: asynchronous return to P0 with a fresh T_VERDE count. The first phase after reset release lasts the full T_VERDE edges.
- No glitches from X: bt=X is treated per simulation semantics. The design needs no initial block; reset is the only initialisation.

Test Plan:
- Reset: rst=0 at t=0, clk idle → A=001, B=100 immediately. Hold rst=0 over several edges → no change.
- Default sequence, bt=0, rst released:
  - Edge1 → A=010, B=100.
  - Edges2-3 hold.
  - Edge4 → A=100, B=001.
  - Edge6 → A=100, B=010.
  - Edge9 → A=001, B=100.
  - The pattern repeats every 9 edges.
- Irregular clock (non-uniform high/low widths, glitch-free): transitions depend only on rising-edge count, not on timing.
- Button shortening with T_VERDE=5: press bt=1 for one edge at the 2nd edge of P0 → A=010 after that edge. Yellow lasts 3 edges, then the normal sequence resumes.
- Button outside P0 (bt=1 held through P1-P3): phase timing identical to the bt=0 case.
- Async reset mid-P2 (rst low between edges) → A=001, B=100 at once, without waiting for a clock edge. After release, P0 lasts T_VERDE edges.
- Invariant check over 100+ random-bt cycles: never both A!=100 and B!=100.
